// File: rtl/bit_serializer.sv
// Parallel-to-serial converter with a small circular input FIFO feeding a shift FSM.
// Latency: a word pushed into an empty, idle block shows its first bit on x one edge later.
// Backpressure: in_ready drops while the FIFO is full; words then back-to-back with no gap bits.
module bit_serializer #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 4,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DATA_W-1:0]            in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic                         x,
  output logic                         x_valid,
  output logic                         frame_start,
  output logic                         busy,
  output logic [$clog2(DEPTH+1)-1:0]   level
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LVL_W = $clog2(DEPTH+1);
  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] sh_q;
  logic              x_q, x_valid_q, frame_start_q;

  logic              full, empty, push, pop, last_bit;
  logic [DATA_W-1:0] head, head_rest, sh_rest;
  logic              head_bit, sh_bit;

  assign full     = (level_q == LVL_W'(DEPTH));
  assign empty    = (level_q == '0);
  assign in_ready = !full && !rst;
  assign push     = in_valid && in_ready;
  assign last_bit = (cnt_q == CNT_W'(DATA_W-1));
  // The shifter only ever pops a word that is already stored; no pass-through.
  assign pop      = !empty && ((state_q == S_IDLE) || last_bit);

  assign head      = mem_q[rd_ptr_q];
  assign head_bit  = MSB_FIRST ? head[DATA_W-1] : head[0];
  assign head_rest = MSB_FIRST ? (head << 1) : (head >> 1);
  assign sh_bit    = MSB_FIRST ? sh_q[DATA_W-1] : sh_q[0];
  assign sh_rest   = MSB_FIRST ? (sh_q << 1) : (sh_q >> 1);

  // Next-state for pointers and occupancy; simultaneous push and pop leaves level unchanged.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push && !pop)      level_d = level_q + LVL_W'(1);
    else if (pop && !push) level_d = level_q - LVL_W'(1);
  end

  // FIFO storage; data needs no reset since level gates every read.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

  // FIFO pointers and occupancy, flushed by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Shifter FSM with registered serial outputs; the last bit of a word reloads directly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      sh_q          <= '0;
      x_q           <= IDLE_BIT;
      x_valid_q     <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pop) begin
            state_q       <= S_SHIFT;
            cnt_q         <= '0;
            sh_q          <= head_rest;
            x_q           <= head_bit;
            x_valid_q     <= 1'b1;
            frame_start_q <= 1'b1;
          end
        end
        S_SHIFT: begin
          if (!last_bit) begin
            cnt_q         <= cnt_q + CNT_W'(1);
            sh_q          <= sh_rest;
            x_q           <= sh_bit;
            frame_start_q <= 1'b0;
          end else if (pop) begin
            cnt_q         <= '0;
            sh_q          <= head_rest;
            x_q           <= head_bit;
            frame_start_q <= 1'b1;
          end else begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            x_q           <= IDLE_BIT;
            x_valid_q     <= 1'b0;
            frame_start_q <= 1'b0;
          end
        end
        default: begin
          state_q       <= S_IDLE;
          cnt_q         <= '0;
          x_q           <= IDLE_BIT;
          x_valid_q     <= 1'b0;
          frame_start_q <= 1'b0;
        end
      endcase
    end
  end

  assign x           = x_q;
  assign x_valid     = x_valid_q;
  assign frame_start = frame_start_q;
  assign busy        = x_valid_q || !empty;
  assign level       = level_q;

endmodule
